pi_spi_master: RTL and testbench

// SPI initiator for the peripheral-interface (PI) link: drives spi_clk/spi_ss/spi_mosi, samples
// spi_miso. It is the MCU-side counterpart of the FPGA PI slave, used for co-processor bridging and
// as the bus-functional driver in system benches. Bursts are framed as command byte, 32-bit address,

---
 rtl/pi_spi_master.sv | 171 +++++++++++++++++
 tb/tb_pi_spi_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_spi_master.sv
// PI link SPI initiator (mode 0): command byte, 32-bit address, then data bytes.
// Write bytes are pulled with valid/ready; read bytes return on an rx strobe.
module pi_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int SS_GAP  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_start,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [15:0] cmd_len,
    output logic        busy,
    output logic        done,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        spi_clk,
    output logic        spi_ss,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [2:0] {
        IDLE, SETUP, HDR, DATA, WAIT_TX, TAIL, GAP
    } state_t;

    localparam int CMAX = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(SS_GAP - 1);

    state_t      state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_cnt;
    logic [2:0]  hdr_cnt;
    logic [15:0] data_cnt;
    logic        wr_q;
    logic [31:0] addr_sh;
    logic [7:0]  tx_sh;
    logic [7:0]  rx_sh;

    logic shifting, cnt_end, rise, fall, byte_end;
    logic hdr_last, data_last, more_data;

    assign shifting  = (state == HDR) || (state == DATA);
    assign cnt_end   = (cnt == HALF_END);
    assign rise      = shifting && !spi_clk && cnt_end;
    assign fall      = shifting && spi_clk && cnt_end;
    assign byte_end  = fall && (bit_cnt == 3'd7);
    assign hdr_last  = (state == HDR) && byte_end && (hdr_cnt == 3'd4);
    assign data_last = (state == DATA) && byte_end && (data_cnt == 16'd1);
    // data_cnt still holds cmd_len while the header is shifting
    assign more_data = (hdr_last && (data_cnt != 16'd0))
                    || ((state == DATA) && byte_end && !data_last);
    assign tx_ready  = wr_q && tx_valid && (more_data || (state == WAIT_TX));
    assign busy      = (state != IDLE);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (cmd_start) state_n = SETUP;
            SETUP:   if (cnt_end) state_n = HDR;
            HDR: begin
                if (hdr_last) begin
                    if (data_cnt == 16'd0)       state_n = TAIL;
                    else if (wr_q && !tx_valid) state_n = WAIT_TX;
                    else                         state_n = DATA;
                end
            end
            DATA: begin
                if (data_last)                           state_n = TAIL;
                else if (byte_end && wr_q && !tx_valid) state_n = WAIT_TX;
            end
            WAIT_TX: if (tx_valid) state_n = DATA;
            TAIL:    if (cnt_end) state_n = GAP;
            GAP:     if (cnt == GAP_END) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if ((state_n != state) || (shifting && cnt_end)) begin
            cnt <= '0;
        end else if ((state != IDLE) && (state != WAIT_TX)) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_ss   <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b1;
            done     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            wr_q     <= 1'b0;
            addr_sh  <= '0;
            data_cnt <= '0;
            bit_cnt  <= '0;
            hdr_cnt  <= '0;
            tx_sh    <= 8'hFF;
            rx_sh    <= 8'h00;
        end else begin
            done     <= 1'b0;
            rx_valid <= 1'b0;
            if ((state == IDLE) && cmd_start) begin
                wr_q     <= cmd_wr;
                addr_sh  <= cmd_addr;
                data_cnt <= cmd_len;
                tx_sh    <= cmd_wr ? 8'hA0 : 8'hA1;
                spi_mosi <= 1'b1;
                spi_ss   <= 1'b0;
                spi_clk  <= 1'b0;
                bit_cnt  <= '0;
                hdr_cnt  <= '0;
            end
            if (rise) begin
                spi_clk <= 1'b1;
                rx_sh   <= {rx_sh[6:0], spi_miso};
            end
            if (fall) begin
                spi_clk  <= 1'b0;
                bit_cnt  <= bit_cnt + 3'd1;
                tx_sh    <= {tx_sh[6:0], 1'b1};
                spi_mosi <= tx_sh[6];
            end
            if ((state == HDR) && byte_end) begin
                hdr_cnt <= hdr_cnt + 3'd1;
                if (!hdr_last) begin
                    tx_sh    <= addr_sh[31:24];
                    spi_mosi <= addr_sh[31];
                    addr_sh  <= {addr_sh[23:0], 8'h00};
                end
            end
            if ((state == DATA) && byte_end) begin
                data_cnt <= data_cnt - 16'd1;
                if (!wr_q) begin
                    rx_data  <= rx_sh;
                    rx_valid <= 1'b1;
                end
            end
            if (more_data && !wr_q) begin
                tx_sh    <= 8'hFF;
                spi_mosi <= 1'b1;
            end
            if (tx_ready) begin
                tx_sh    <= tx_data;
                spi_mosi <= tx_data[7];
            end
            if ((hdr_last && (data_cnt == 16'd0)) || data_last) begin
                spi_mosi <= 1'b1;
            end
            if ((state == TAIL) && cnt_end) begin
                spi_ss <= 1'b1;
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pi_spi_master.sv
// Bench for pi_spi_master: slave model decodes mosi, serves miso,
// and counts edges/strobes; vectors in a table plus corner sequences.
module tb_pi_spi_master;

    localparam int CLK_DIV = 2;
    localparam int SS_GAP  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        busy, done;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        spi_clk, spi_ss, spi_mosi;
    logic        spi_miso;

    pi_spi_master #(.CLK_DIV(CLK_DIV), .SS_GAP(SS_GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_start(cmd_start), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .busy(busy), .done(done),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .spi_clk(spi_clk), .spi_ss(spi_ss),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // slave-side monitors
    int          n_ss_low = 0, n_txr = 0, n_done = 0, n_rise = 0;
    int          hi_run = 0, last_gap = 0;
    int          fbits = 0;
    logic [7:0]  sh = '0;
    logic [7:0]  mosi_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  fm[16];
    logic [7:0]  tx_buf[4];

    always @(negedge clk) begin
        if (!spi_ss) n_ss_low++;
        if (tx_ready) n_txr++;
        if (done) n_done++;
        if (rx_valid) rx_q.push_back(rx_data);
        if (spi_ss) hi_run++;
        else begin
            if (hi_run != 0) last_gap = hi_run;
            hi_run = 0;
        end
    end

    always @(posedge spi_clk or negedge spi_ss) begin
        if (spi_clk) begin
            sh = {sh[6:0], spi_mosi};
            fbits++;
            n_rise++;
            if (fbits[2:0] == 3'd0) mosi_q.push_back(sh);
        end else begin
            fbits = 0;
        end
    end

    always_comb begin
        spi_miso = 1'b1;
        if ((fbits >> 3) < 16)
            spi_miso = fm[fbits >> 3][3'd7 - 3'(fbits)];
    end

    task automatic run_burst(input logic wr, input logic [31:0] addr,
                             input logic [15:0] len, input int stall_idx,
                             input int stall_clks, input int poke_at,
                             input int max_cyc, output int bad_win,
                             output bit timed_out);
        int  tx_idx = 0;
        int  stall_left = 0;
        bit  take;
        bad_win = 0;
        timed_out = 1'b0;
        @(negedge clk);
        cmd_wr = wr; cmd_addr = addr; cmd_len = len; cmd_start = 1'b1;
        tx_data = tx_buf[0];
        tx_valid = wr && (len != 0);
        @(posedge clk); #1;
        cmd_start = 1'b0;
        cmd_addr = 32'h5555_5555;
        for (int cyc = 1; ; cyc++) begin
            @(negedge clk);
            if (!busy) break;
            if (cyc >= max_cyc) begin
                timed_out = 1'b1;
                break;
            end
            take = tx_ready;
            if (stall_left > 0 && stall_left <= stall_clks - 40
                && (spi_clk || spi_ss)) bad_win++;
            if (cyc == poke_at) begin
                cmd_start = 1'b1; cmd_wr = ~wr;
                cmd_addr = 32'hBAD0_0000; cmd_len = 16'd7;
            end
            @(posedge clk); #1;
            cmd_start = 1'b0;
            if (take) begin
                tx_idx++;
                if (tx_idx == stall_idx) stall_left = stall_clks;
            end
            if (stall_left > 0) begin
                stall_left--;
                tx_valid = 1'b0;
            end else begin
                tx_valid = wr && (tx_idx < int'(len));
            end
            if (tx_idx < 4) tx_data = tx_buf[tx_idx];
        end
        tx_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic wr,
                               input logic [31:0] addr,
                               input logic [15:0] len,
                               input logic [31:0] d, input int base);
        logic [7:0] exp[9];
        exp[0] = wr ? 8'hA0 : 8'hA1;
        exp[1] = addr[31:24]; exp[2] = addr[23:16];
        exp[3] = addr[15:8];  exp[4] = addr[7:0];
        for (int i = 0; i < 4; i++)
            exp[5 + i] = wr ? d[31 - 8*i -: 8] : 8'hFF;
        chk({tag, " nbytes"}, mosi_q.size() - base, 5 + len);
        for (int i = 0; i < 5 + int'(len) && i < 9; i++)
            if (base + i < mosi_q.size())
                chk($sformatf("%s mosi[%0d]", tag, i),
                    mosi_q[base + i], exp[i]);
    endtask

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [15:0] len;
        logic [31:0] d;
        logic [15:0] rises;
        logic [15:0] ss_low;
        logic [3:0]  txr;
        logic [3:0]  rxv;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int  bw, b0, r0, s0, t0, d0, e0;
        bit  to;
        vecs[0] = '{1'b1, 32'h0000_1234, 16'd2, 32'h1122_0000,
                    16'd56, 16'd228, 4'd2, 4'd0};
        vecs[1] = '{1'b0, 32'h0100_0000, 16'd3, 32'h5AC3_0F00,
                    16'd64, 16'd260, 4'd0, 4'd3};
        vecs[2] = '{1'b1, 32'hDEAD_BEEF, 16'd0, 32'h0000_0000,
                    16'd40, 16'd164, 4'd0, 4'd0};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF, 16'd1, 32'h8100_0000,
                    16'd48, 16'd196, 4'd0, 4'd1};
        vecs[4] = '{1'b1, 32'h8000_0001, 16'd1, 32'h7E00_0000,
                    16'd48, 16'd196, 4'd1, 4'd0};
        for (int i = 0; i < 16; i++) fm[i] = 8'h00;

        #12;
        chk("rst ss", spi_ss, 1);
        chk("rst clk", spi_clk, 0);
        chk("rst mosi", spi_mosi, 1);
        chk("rst busy", busy, 0);
        chk("rst strobes", {done, tx_ready, rx_valid}, 0);
        chk("rst rx_data", rx_data, 8'h00);
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[k]) begin
            for (int i = 0; i < 4; i++) begin
                tx_buf[i] = vecs[k].d[31 - 8*i -: 8];
                fm[5 + i] = vecs[k].d[31 - 8*i -: 8];
            end
            b0 = mosi_q.size(); r0 = rx_q.size(); s0 = n_ss_low;
            t0 = n_txr; d0 = n_done; e0 = n_rise;
            run_burst(vecs[k].wr, vecs[k].addr, vecs[k].len,
                      -1, 0, 0, 2000, bw, to);
            chk($sformatf("v%0d timeout", k), 32'(to), 0);
            chk($sformatf("v%0d done", k), n_done - d0, 1);
            chk($sformatf("v%0d rises", k), n_rise - e0, vecs[k].rises);
            chk($sformatf("v%0d ss_low", k), n_ss_low - s0, vecs[k].ss_low);
            chk($sformatf("v%0d tx_ready", k), n_txr - t0, vecs[k].txr);
            chk($sformatf("v%0d rx_valid", k), rx_q.size() - r0, vecs[k].rxv);
            for (int i = 0; i < int'(vecs[k].rxv); i++)
                if (r0 + i < rx_q.size())
                    chk($sformatf("v%0d rx[%0d]", k, i), rx_q[r0 + i],
                        vecs[k].d[31 - 8*i -: 8]);
            check_frame($sformatf("v%0d", k), vecs[k].wr, vecs[k].addr,
                        vecs[k].len, vecs[k].d, b0);
        end

        // write stall before third data byte
        tx_buf[0] = 8'h96; tx_buf[1] = 8'h69;
        tx_buf[2] = 8'hA5; tx_buf[3] = 8'h3C;
        b0 = mosi_q.size(); t0 = n_txr; d0 = n_done; e0 = n_rise;
        run_burst(1'b1, 32'h0000_00C0, 16'd4, 2, 80, 0, 3000, bw, to);
        chk("stall timeout", 32'(to), 0);
        chk("stall window", bw, 0);
        chk("stall rises", n_rise - e0, 72);
        chk("stall tx_ready", n_txr - t0, 4);
        chk("stall done", n_done - d0, 1);
        check_frame("stall", 1'b1, 32'h0000_00C0, 16'd4, 32'h9669_A53C, b0);

        // reset in bit 5 of the first address byte
        d0 = n_done;
        run_burst(1'b1, 32'hF0F0_0000, 16'd2, -1, 0, 0, 58, bw, to);
        chk("abort reached", 32'(to), 1);
        chk("abort ss low", spi_ss, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort ss", spi_ss, 1);
        chk("abort clk", spi_clk, 0);
        chk("abort busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("abort no done", n_done - d0, 0);
        rst_n = 1'b1;
        fm[5] = 8'hC6;
        b0 = mosi_q.size(); r0 = rx_q.size();
        run_burst(1'b0, 32'h0102_0304, 16'd1, -1, 0, 0, 2000, bw, to);
        chk("post timeout", 32'(to), 0);
        chk("post rx", (rx_q.size() > r0) ? rx_q[r0] : 8'hxx, 8'hC6);
        check_frame("post", 1'b0, 32'h0102_0304, 16'd1, 32'h0, b0);

        // cmd_start while busy, then back-to-back bursts
        tx_buf[0] = 8'h5A;
        b0 = mosi_q.size(); d0 = n_done;
        run_burst(1'b1, 32'h0000_0042, 16'd1, -1, 0, 10, 2000, bw, to);
        chk("poke timeout", 32'(to), 0);
        check_frame("poke", 1'b1, 32'h0000_0042, 16'd1, 32'h5A00_0000, b0);
        b0 = mosi_q.size();
        run_burst(1'b1, 32'h0000_0043, 16'd0, -1, 0, 0, 2000, bw, to);
        chk("b2b timeout", 32'(to), 0);
        chk("b2b done", n_done - d0, 2);
        chk("b2b gap", 32'(last_gap >= SS_GAP), 1);
        check_frame("b2b", 1'b1, 32'h0000_0043, 16'd0, 32'h0, b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
